// File: rtl/tlb_refill_pkg.sv
// Shared types and constants for the TLB entry store and its refill walker.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package tlb_pkg;

    localparam int VPN_BITS = 27;
    localparam int PPN_BITS = 20;
    // Fixed at 8: the downstream permission checker works on 8-bit vectors.
    localparam int ENTRIES  = 8;

    typedef enum logic [1:0] {
        S_READY    = 2'd0,
        S_REQUEST  = 2'd1,
        S_WAIT     = 2'd2,
        S_WAIT_INV = 2'd3
    } state_t;

    typedef struct packed {
        logic [PPN_BITS-1:0] ppn;
        logic                u;
        logic                r;
        logic                w;
        logic                x;
        logic                d;
    } pte_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [ENTRIES-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tlb_refill_if.sv
// Bundles the lookup request/response, checker vectors and PTW handshake.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates lookups; ptw_req_valid/ptw_req_ready handshake to the walker.
interface tlb_refill_if;
    import tlb_pkg::*;

    // lookup side
    logic                req_valid;
    logic [VPN_BITS-1:0] req_vpn;
    logic                req_store;
    logic                req_passthrough;
    logic                req_ready;
    logic                resp_miss;
    logic [PPN_BITS-1:0] resp_ppn;

    // checker side
    logic [ENTRIES:0]    hits;
    logic [ENTRIES-1:0]  u_array;
    logic [ENTRIES-1:0]  sr_array;
    logic [ENTRIES-1:0]  sw_array;
    logic [ENTRIES-1:0]  sx_array;
    logic [ENTRIES-1:0]  xr_array;
    logic [ENTRIES-1:0]  dirty_array;
    logic [ENTRIES:0]    dirty_hit_check;
    logic                invalidate;

    // page-table walker side
    logic                ptw_req_valid;
    logic                ptw_req_ready;
    logic [VPN_BITS-1:0] ptw_req_vpn;
    logic                ptw_req_store;
    logic                ptw_resp_valid;
    logic [PPN_BITS-1:0] ptw_resp_ppn;
    logic                ptw_resp_u;
    logic                ptw_resp_r;
    logic                ptw_resp_w;
    logic                ptw_resp_x;
    logic                ptw_resp_d;
    logic                ptw_resp_error;

    // The TLB itself
    modport slave (
        input  req_valid, req_vpn, req_store, req_passthrough,
        output req_ready, resp_miss, resp_ppn,
        output hits, u_array, sr_array, sw_array, sx_array, xr_array, dirty_array,
        input  dirty_hit_check, invalidate,
        output ptw_req_valid, ptw_req_vpn, ptw_req_store,
        input  ptw_req_ready,
        input  ptw_resp_valid, ptw_resp_ppn, ptw_resp_u, ptw_resp_r,
        input  ptw_resp_w, ptw_resp_x, ptw_resp_d, ptw_resp_error
    );

    // The surrounding pipeline, checker and walker
    modport master (
        output req_valid, req_vpn, req_store, req_passthrough,
        input  req_ready, resp_miss, resp_ppn,
        input  hits, u_array, sr_array, sw_array, sx_array, xr_array, dirty_array,
        output dirty_hit_check, invalidate,
        input  ptw_req_valid, ptw_req_vpn, ptw_req_store,
        output ptw_req_ready,
        output ptw_resp_valid, ptw_resp_ppn, ptw_resp_u, ptw_resp_r,
        output ptw_resp_w, ptw_resp_x, ptw_resp_d, ptw_resp_error
    );

endinterface

// File: rtl/tlb_refill_plru8.sv
// 8-way tree pseudo-LRU: 7 node bits, root at bit 0, level 2 at bits 1-2, leaves' parents at 3-6.
// Latency: victim_idx is combinational from state; an access updates state on the next edge.
// Backpressure: none; an access is taken whenever upd_vld is high.
module tlb_plru8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       upd_vld,
    input  logic [2:0] upd_idx,
    output logic [2:0] victim_idx
);

    logic [6:0] tree_q;
    logic [6:0] tree_d;
    logic [2:0] node_l2;
    logic [2:0] node_l3;

    // A node bit of 1 steers the victim to the lower-index half; an access
    // sets each node on its path to point at the half it did not touch.
    always_comb begin
        tree_d  = tree_q;
        node_l2 = {2'b00, upd_idx[2]} + 3'd1;
        node_l3 = {1'b0, upd_idx[2:1]} + 3'd3;
        if (upd_vld) begin
            tree_d[0]       = upd_idx[2];
            tree_d[node_l2] = upd_idx[1];
            tree_d[node_l3] = upd_idx[0];
        end
    end

    // Walk from the root following the node bits to the victim leaf.
    always_comb begin
        victim_idx    = '0;
        victim_idx[2] = ~tree_q[0];
        victim_idx[1] = ~tree_q[{2'b00, victim_idx[2]} + 3'd1];
        victim_idx[0] = ~tree_q[{1'b0, victim_idx[2:1]} + 3'd3];
    end

    // Tree state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tree_q <= '0;
        else          tree_q <= tree_d;
    end

endmodule

// File: rtl/tlb_refill.sv
// 8-entry fully-associative TLB store with combinational lookup and a PTW refill FSM.
// Latency: lookup/hit/miss in the same cycle; a miss issues ptw_req_valid on the next cycle.
// Backpressure: req_ready is low from a miss until the refill (or its cancellation) completes.
module tlb_refill
    import tlb_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    tlb_refill_if.slave bus
);

    state_t              state_q, state_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [VPN_BITS-1:0] tag_q [ENTRIES];
    logic [VPN_BITS-1:0] tag_d [ENTRIES];
    pte_t                pte_q [ENTRIES];
    pte_t                pte_d [ENTRIES];
    logic [VPN_BITS-1:0] r_vpn_q, r_vpn_d;
    logic                r_store_q, r_store_d;
    logic [2:0]          r_victim_q, r_victim_d;
    logic                ptw_req_valid_q, ptw_req_valid_d;

    logic [ENTRIES-1:0]  tag_hit;
    logic [ENTRIES-1:0]  hit_ok;
    logic [PPN_BITS-1:0] hit_ppn;
    logic                req_ready;
    logic                miss;
    logic                hit_access;
    logic [2:0]          hit_idx;
    logic [2:0]          victim;
    logic [2:0]          plru_victim;
    logic                plru_upd;
    logic [2:0]          plru_idx;
    pte_t                fill_pte;
    logic [ENTRIES-1:0]  u_arr, r_arr, w_arr, x_arr, d_arr;
    logic                unused_dhc_pt;

    // Bit 8 of the checker vector mirrors passthrough and carries no entry information.
    assign unused_dhc_pt = bus.dirty_hit_check[ENTRIES];

    // Tag compare against every entry and OR-merge of the hitting PPNs.
    always_comb begin
        tag_hit = '0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            tag_hit[i] = valid_q[i] && (tag_q[i] == bus.req_vpn);
            if (tag_hit[i]) hit_ppn = hit_ppn | pte_q[i].ppn;
        end
    end

    assign req_ready  = (state_q == S_READY);
    // A zero in the checker's vector (e.g. store to a clean page) turns a tag hit into a miss.
    assign hit_ok     = tag_hit & bus.dirty_hit_check[ENTRIES-1:0];
    assign miss       = bus.req_valid && req_ready && !bus.req_passthrough && (hit_ok == '0);
    assign hit_access = bus.req_valid && req_ready && !bus.req_passthrough && !miss;
    assign hit_idx    = lowest_set(hit_ok);

    // Refill over a stale tag match first so a VPN never lives in two entries,
    // then fill empty slots, and only then evict by pseudo-LRU.
    assign victim = (|tag_hit)  ? lowest_set(tag_hit)  :
                    (~&valid_q) ? lowest_set(~valid_q) : plru_victim;

    // An erroring walk installs a valid entry with no permissions so the replay faults.
    always_comb begin
        fill_pte     = '0;
        fill_pte.ppn = bus.ptw_resp_ppn;
        fill_pte.u   = bus.ptw_resp_u && !bus.ptw_resp_error;
        fill_pte.r   = bus.ptw_resp_r && !bus.ptw_resp_error;
        fill_pte.w   = bus.ptw_resp_w && !bus.ptw_resp_error;
        fill_pte.x   = bus.ptw_resp_x && !bus.ptw_resp_error;
        fill_pte.d   = bus.ptw_resp_d;
    end

    // Refill FSM next-state, entry writes, flushes and pseudo-LRU access requests.
    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        tag_d           = tag_q;
        pte_d           = pte_q;
        r_vpn_d         = r_vpn_q;
        r_store_d       = r_store_q;
        r_victim_d      = r_victim_q;
        ptw_req_valid_d = ptw_req_valid_q;
        plru_upd        = 1'b0;
        plru_idx        = r_victim_q;
        case (state_q)
            S_READY: begin
                // Lookup used pre-flush state, so a coincident miss is still taken.
                if (bus.invalidate) valid_d = '0;
                if (miss) begin
                    r_vpn_d         = bus.req_vpn;
                    r_store_d       = bus.req_store;
                    r_victim_d      = victim;
                    ptw_req_valid_d = 1'b1;
                    state_d         = S_REQUEST;
                end else if (hit_access) begin
                    plru_upd = 1'b1;
                    plru_idx = hit_idx;
                end
            end
            S_REQUEST: begin
                if (bus.ptw_req_ready) begin
                    ptw_req_valid_d = 1'b0;
                    if (bus.invalidate) begin
                        valid_d = '0;
                        state_d = S_WAIT_INV;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (bus.invalidate) begin
                    // Walk not yet accepted: simply abandon it.
                    ptw_req_valid_d = 1'b0;
                    valid_d         = '0;
                    state_d         = S_READY;
                end
            end
            S_WAIT: begin
                if (bus.ptw_resp_valid) begin
                    valid_d[r_victim_q] = 1'b1;
                    tag_d[r_victim_q]   = r_vpn_q;
                    pte_d[r_victim_q]   = fill_pte;
                    plru_upd            = 1'b1;
                    state_d             = S_READY;
                    if (bus.invalidate) valid_d = '0;
                end else if (bus.invalidate) begin
                    valid_d = '0;
                    state_d = S_WAIT_INV;
                end
            end
            S_WAIT_INV: begin
                // The walk was for a flushed context: swallow its response.
                if (bus.invalidate)     valid_d = '0;
                if (bus.ptw_resp_valid) state_d = S_READY;
            end
            default: state_d = S_READY;
        endcase
    end

    // FSM, entry store and walk request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_READY;
            valid_q         <= '0;
            r_vpn_q         <= '0;
            r_store_q       <= 1'b0;
            r_victim_q      <= '0;
            ptw_req_valid_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                pte_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            r_vpn_q         <= r_vpn_d;
            r_store_q       <= r_store_d;
            r_victim_q      <= r_victim_d;
            ptw_req_valid_q <= ptw_req_valid_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= tag_d[i];
                pte_q[i] <= pte_d[i];
            end
        end
    end

    tlb_plru8 u_plru (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd_vld    (plru_upd),
        .upd_idx    (plru_idx),
        .victim_idx (plru_victim)
    );

    // Per-entry attribute vectors for the checker; X feeds both execute and X-readable.
    always_comb begin
        u_arr = '0;
        r_arr = '0;
        w_arr = '0;
        x_arr = '0;
        d_arr = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            u_arr[i] = pte_q[i].u;
            r_arr[i] = pte_q[i].r;
            w_arr[i] = pte_q[i].w;
            x_arr[i] = pte_q[i].x;
            d_arr[i] = pte_q[i].d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.resp_miss     = miss;
    assign bus.resp_ppn      = bus.req_passthrough ? bus.req_vpn[PPN_BITS-1:0] : hit_ppn;
    assign bus.hits          = {bus.req_passthrough, tag_hit};
    assign bus.u_array       = u_arr;
    assign bus.sr_array      = r_arr;
    assign bus.sw_array      = w_arr;
    assign bus.sx_array      = x_arr;
    assign bus.xr_array      = x_arr;
    assign bus.dirty_array   = d_arr;
    assign bus.ptw_req_valid = ptw_req_valid_q;
    assign bus.ptw_req_vpn   = r_vpn_q;
    assign bus.ptw_req_store = r_store_q;

endmodule

// File: tb/tb_tlb_refill.sv
// Randomised and directed bench for tlb_refill against a behavioural TLB model.
// Latency: inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpressure: bench plays requester, checker and page-table walker.
module tb_tlb_refill;
    import tlb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    tlb_refill_if bus();

    tlb_refill dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural TLB model ----------------
    bit                  m_valid [8];
    logic [VPN_BITS-1:0] m_tag   [8];
    logic [PPN_BITS-1:0] m_ppn   [8];
    bit m_u [8], m_r [8], m_w [8], m_x [8], m_d [8];
    bit m_tree [7];   // heap-ordered binary tree, node n has children 2n+1 (low) and 2n+2 (high)

    logic [VPN_BITS-1:0] pend_vpn;
    bit                  pend_store;
    int                  pend_victim;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_ppn[i] = '0;
            m_u[i] = 0; m_r[i] = 0; m_w[i] = 0; m_x[i] = 0; m_d[i] = 0;
        end
        for (int n = 0; n < 7; n++) m_tree[n] = 0;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
    endfunction

    function automatic int first_one(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] model_hits(input logic [VPN_BITS-1:0] vpn);
        logic [7:0] h = '0;
        for (int i = 0; i < 8; i++) h[i] = m_valid[i] && (m_tag[i] == vpn);
        return h;
    endfunction

    function automatic logic [PPN_BITS-1:0] model_ppn(input logic [7:0] h);
        logic [PPN_BITS-1:0] p = '0;
        for (int i = 0; i < 8; i++) if (h[i]) p = p | m_ppn[i];
        return p;
    endfunction

    // Checker's view: a store needs the dirty bit, otherwise every hit is usable.
    function automatic logic [8:0] checker_dhc(input bit store);
        logic [8:0] v = 9'h1FF;
        for (int i = 0; i < 8; i++) v[i] = !(store && !m_d[i]);
        return v;
    endfunction

    function automatic void model_touch(input int idx);
        int  n = 0;
        bit  hi;
        for (int l = 2; l >= 0; l--) begin
            hi = ((idx >> l) & 1) != 0;
            m_tree[n] = hi;               // steer future victims to the other half
            n = hi ? 2 * n + 2 : 2 * n + 1;
        end
    endfunction

    function automatic int model_victim(input logic [7:0] h);
        int n = 0;
        if (h != 0) return first_one(h);
        for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
        for (int l = 0; l < 3; l++) n = m_tree[n] ? 2 * n + 1 : 2 * n + 2;
        return n - 7;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #4;
    endtask

    task automatic check_arrays();
        logic [7:0] eu, er, ew, ex, ed;
        for (int i = 0; i < 8; i++) begin
            eu[i] = m_u[i]; er[i] = m_r[i]; ew[i] = m_w[i]; ex[i] = m_x[i]; ed[i] = m_d[i];
        end
        check("u_array", bus.u_array, eu);
        check("sr_array", bus.sr_array, er);
        check("sw_array", bus.sw_array, ew);
        check("sx_array", bus.sx_array, ex);
        check("xr_array", bus.xr_array, ex);
        check("dirty_array", bus.dirty_array, ed);
    endtask

    // Observe valid bits through the hit vector without issuing requests.
    task automatic probe_valids();
        for (int i = 0; i < 8; i++) begin
            bus.req_vpn = m_tag[i];
            @(negedge clk);
            check("probe_hits", bus.hits, {1'b0, model_hits(m_tag[i])});
        end
        tick();
    endtask

    task automatic probe_const(input string tag, input logic [VPN_BITS-1:0] vpn,
                               input logic [8:0] exp_hits);
        bus.req_vpn = vpn;
        sample();
        check(tag, bus.hits, exp_hits);
        tick();
    endtask

    task automatic do_lookup(input logic [VPN_BITS-1:0] vpn, input bit store, input bit pt,
                             output bit missed);
        logic [7:0] hv;
        logic [8:0] dhc;
        bit         em;
        dhc                 = checker_dhc(store);
        bus.req_valid       = 1'b1;
        bus.req_vpn         = vpn;
        bus.req_store       = store;
        bus.req_passthrough = pt;
        bus.dirty_hit_check = dhc;
        sample();
        hv = model_hits(vpn);
        em = !pt && ((hv & dhc[7:0]) == 8'h00);
        check("hits", bus.hits, {pt, hv});
        check("resp_miss", bus.resp_miss, em);
        check("resp_ppn", bus.resp_ppn, pt ? vpn[PPN_BITS-1:0] : model_ppn(hv));
        check("req_ready", bus.req_ready, 1'b1);
        missed = em;
        if (em) begin
            pend_vpn    = vpn;
            pend_store  = store;
            pend_victim = model_victim(hv);
        end else if (!pt) begin
            model_touch(first_one(hv & dhc[7:0]));
        end
        tick();
        bus.req_valid       = 1'b0;
        bus.req_store       = 1'b0;
        bus.req_passthrough = 1'b0;
        bus.dirty_hit_check = 9'h1FF;
    endtask

    // Entered one cycle after the miss; leaves the DUT waiting for the PTE.
    task automatic walk_accept(input int rdly);
        sample();
        check("ptw_req_valid", bus.ptw_req_valid, 1'b1);
        check("ptw_req_vpn", bus.ptw_req_vpn, pend_vpn);
        check("ptw_req_store", bus.ptw_req_store, pend_store);
        check("busy_not_ready", bus.req_ready, 1'b0);
        tick();
        repeat (rdly) tick();
        bus.ptw_req_ready = 1'b1;
        tick();
        bus.ptw_req_ready = 1'b0;
        sample();
        check("ptw_req_drop", bus.ptw_req_valid, 1'b0);
        tick();
    endtask

    task automatic pulse_resp(input logic [PPN_BITS-1:0] ppn, input bit u, input bit r,
                              input bit w, input bit x, input bit d, input bit err);
        bus.ptw_resp_valid = 1'b1;
        bus.ptw_resp_ppn   = ppn;
        bus.ptw_resp_u = u; bus.ptw_resp_r = r; bus.ptw_resp_w = w;
        bus.ptw_resp_x = x; bus.ptw_resp_d = d; bus.ptw_resp_error = err;
        tick();
        bus.ptw_resp_valid = 1'b0;
        bus.ptw_resp_error = 1'b0;
    endtask

    task automatic walk_respond(input int wdly, input logic [PPN_BITS-1:0] ppn, input bit u,
                                input bit r, input bit w, input bit x, input bit d, input bit err);
        repeat (wdly) tick();
        pulse_resp(ppn, u, r, w, x, d, err);
        m_valid[pend_victim] = 1;
        m_tag[pend_victim]   = pend_vpn;
        m_ppn[pend_victim]   = ppn;
        m_u[pend_victim] = u && !err; m_r[pend_victim] = r && !err;
        m_w[pend_victim] = w && !err; m_x[pend_victim] = x && !err;
        m_d[pend_victim] = d;
        model_touch(pend_victim);
        sample();
        check("ready_after_fill", bus.req_ready, 1'b1);
        check_arrays();
        tick();
    endtask

    task automatic refill(input logic [VPN_BITS-1:0] vpn, input bit store,
                          input logic [PPN_BITS-1:0] ppn, input bit u, input bit r,
                          input bit w, input bit x, input bit d, input bit err);
        bit missed;
        do_lookup(vpn, store, 1'b0, missed);
        check("expect_miss", missed, 1'b1);
        if (missed) begin
            walk_accept(0);
            walk_respond(1, ppn, u, r, w, x, d, err);
        end
    endtask

    task automatic flush_ready();
        bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        model_flush();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    logic [VPN_BITS-1:0] pool [12];
    logic [VPN_BITS-1:0] hit_order [7];

    initial begin
        bit missed;
        int r;

        bus.req_valid = 0; bus.req_vpn = '0; bus.req_store = 0; bus.req_passthrough = 0;
        bus.dirty_hit_check = 9'h1FF; bus.invalidate = 0; bus.ptw_req_ready = 0;
        bus.ptw_resp_valid = 0; bus.ptw_resp_ppn = '0; bus.ptw_resp_u = 0; bus.ptw_resp_r = 0;
        bus.ptw_resp_w = 0; bus.ptw_resp_x = 0; bus.ptw_resp_d = 0; bus.ptw_resp_error = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hits", bus.hits, 9'h000);
        check("rst_miss", bus.resp_miss, 1'b0);
        check("rst_ptw_valid", bus.ptw_req_valid, 1'b0);
        check("rst_ready", bus.req_ready, 1'b1);
        check_arrays();
        tick();
        reset_n = 1'b1;
        tick();

        // First miss, refill into entry 0 and re-lookup
        refill(27'h1234, 1'b0, 20'hABC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        probe_const("first_hit", 27'h1234, 9'h001);
        do_lookup(27'h1234, 1'b0, 1'b0, missed);

        // Fill entries 1..7; entry 3 left clean for the dirty-refill case
        for (int i = 1; i < 8; i++)
            refill(27'h100 + 27'(i), 1'b0, 20'(32'h5000 + i), 1'b1, 1'b1, i != 3, 1'b1,
                   i != 3, 1'b0);
        probe_valids();

        // Touch 0..6 in an order that leaves entry 7 as the tree victim
        hit_order[0] = 27'h106; hit_order[1] = 27'h104; hit_order[2] = 27'h105;
        hit_order[3] = 27'h1234; hit_order[4] = 27'h101; hit_order[5] = 27'h102;
        hit_order[6] = 27'h103;
        for (int k = 0; k < 7; k++) begin
            do_lookup(hit_order[k], 1'b0, 1'b0, missed);
            check("expect_hit", missed, 1'b0);
        end
        refill(27'h777, 1'b0, 20'h777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        probe_const("plru_victim7", 27'h777, 9'h080);
        probe_valids();

        // Store to clean entry 3: refill lands on entry 3 itself
        refill(27'h103, 1'b1, 20'h33333, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        probe_const("dirty_refill_one_hit", 27'h103, 9'h008);
        probe_valids();

        // Passthrough bypasses translation
        bus.req_valid = 1'b1; bus.req_passthrough = 1'b1; bus.req_vpn = 27'h2ABCDEF;
        sample();
        check("pt_hits", bus.hits, 9'h100);
        check("pt_miss", bus.resp_miss, 1'b0);
        check("pt_ppn", bus.resp_ppn, 20'hBCDEF);
        tick();
        bus.req_valid = 1'b0; bus.req_passthrough = 1'b0;

        // Faulting walk installs a valid entry with no permissions
        refill(27'h4444, 1'b0, 20'h4444, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        probe_valids();

        // Invalidate while waiting for the PTE: response is dropped
        do_lookup(27'h5555, 1'b0, 1'b0, missed);
        walk_accept(1);
        bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        model_flush();
        sample();
        check("wait_inv_busy", bus.req_ready, 1'b0);
        tick();
        pulse_resp(20'hFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        sample();
        check("wait_inv_ready", bus.req_ready, 1'b1);
        check_arrays();
        tick();
        probe_const("wait_inv_nowrite", 27'h5555, 9'h000);
        probe_valids();

        // Invalidate before the walker accepts: request withdrawn
        do_lookup(27'h6666, 1'b0, 1'b0, missed);
        sample();
        check("req_inv_valid_before", bus.ptw_req_valid, 1'b1);
        tick();
        bus.invalidate = 1'b1;
        tick();
        bus.invalidate = 1'b0;
        model_flush();
        sample();
        check("req_inv_drop", bus.ptw_req_valid, 1'b0);
        check("req_inv_ready", bus.req_ready, 1'b1);
        tick();

        // Randomised traffic over a VPN pool larger than the TLB
        for (int k = 0; k < 12; k++) pool[k] = 27'h40000 + 27'(k * 3);
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                flush_ready();
            end else begin
                do_lookup(pool[$urandom_range(0, 11)], 1'($urandom_range(0, 1)), r < 12, missed);
                if (missed) begin
                    walk_accept($urandom_range(0, 2));
                    walk_respond($urandom_range(0, 3), PPN_BITS'($urandom),
                                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                 1'($urandom), $urandom_range(0, 9) == 0);
                end
            end
            if (it % 50 == 49) probe_valids();
        end

        // Reset during a walk; the late response must be ignored
        do_lookup(27'h7ABCD, 1'b0, 1'b0, missed);
        if (missed) walk_accept(0);
        reset_n = 1'b0;
        model_reset();
        sample();
        check("midrst_ptw_valid", bus.ptw_req_valid, 1'b0);
        check("midrst_ready", bus.req_ready, 1'b1);
        check_arrays();
        tick();
        reset_n = 1'b1;
        tick();
        pulse_resp(20'h12345, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        sample();
        check("midrst_ready_after", bus.req_ready, 1'b1);
        check_arrays();
        tick();
        probe_const("midrst_nowrite", 27'h7ABCD, 9'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
